// File: rtl/sc_button_conditioner.sv
// Debounces the raw active-low clear/load pushbuttons into clean synchronous levels.
// Optional mutual exclusion of the two channels: SC_BUTTONCONDITIONER_LOCKOUT_EN.
module sc_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19
) (
    input  logic SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic SC_STATEMACHINEGENERAL_RESET_InHigh,
    input  logic SC_BUTTONCONDITIONER_clearRaw_InLow,
    input  logic SC_BUTTONCONDITIONER_loadRaw_InLow,
    output logic SC_BUTTONCONDITIONER_clear_OutLow,
    output logic SC_BUTTONCONDITIONER_load_OutLow
);

    localparam logic [1:0] IDLE_HIGH  = 2'd0;
    localparam logic [1:0] WAIT_LOW   = 2'd1;
    localparam logic [1:0] STABLE_LOW = 2'd2;
    localparam logic [1:0] WAIT_HIGH  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Channel 0 is clear, channel 1 is load.
    logic [1:0]           raw;
    logic [1:0]           s1;
    logic [1:0]           s2;
    logic [1:0]           allow;
    logic [1:0]           outq;
    logic [1:0]           outNxt;
    logic [1:0]           state    [2];
    logic [1:0]           stateNxt [2];
    logic [CNT_WIDTH-1:0] cnt      [2];
    logic [CNT_WIDTH-1:0] cntNxt   [2];

    assign raw = {SC_BUTTONCONDITIONER_loadRaw_InLow,
                  SC_BUTTONCONDITIONER_clearRaw_InLow};

    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or
                posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            s1 <= 2'b11;
            s2 <= 2'b11;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef SC_BUTTONCONDITIONER_LOCKOUT_EN
    logic clearEnter;

    // Clear has priority when both would start qualifying on the same edge.
    always_comb begin
        allow[0]   = outq[1] && (state[1] != WAIT_LOW);
        clearEnter = (state[0] == IDLE_HIGH) && !s2[0] && allow[0];
        allow[1]   = outq[0] && (state[0] != WAIT_LOW) && !clearEnter;
    end
`else
    assign allow = 2'b11;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stateNxt[i] = state[i];
            cntNxt[i]   = cnt[i];
            outNxt[i]   = outq[i];
            case (state[i])
                IDLE_HIGH: begin
                    outNxt[i] = 1'b1;
                    cntNxt[i] = CNT_ZERO;
                    if (!s2[i] && allow[i]) begin
                        stateNxt[i] = WAIT_LOW;
                        cntNxt[i]   = CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    outNxt[i] = 1'b1;
                    if (s2[i]) begin
                        stateNxt[i] = IDLE_HIGH;
                        cntNxt[i]   = CNT_ZERO;
                    end else if (cnt[i] == CNT_LAST) begin
                        stateNxt[i] = STABLE_LOW;
                        cntNxt[i]   = CNT_ZERO;
                        outNxt[i]   = 1'b0;
                    end else begin
                        cntNxt[i] = cnt[i] + CNT_ONE;
                    end
                end
                STABLE_LOW: begin
                    outNxt[i] = 1'b0;
                    cntNxt[i] = CNT_ZERO;
                    if (s2[i]) begin
                        stateNxt[i] = WAIT_HIGH;
                        cntNxt[i]   = CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    outNxt[i] = 1'b0;
                    if (!s2[i]) begin
                        stateNxt[i] = STABLE_LOW;
                        cntNxt[i]   = CNT_ZERO;
                    end else if (cnt[i] == CNT_LAST) begin
                        stateNxt[i] = IDLE_HIGH;
                        cntNxt[i]   = CNT_ZERO;
                        outNxt[i]   = 1'b1;
                    end else begin
                        cntNxt[i] = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    stateNxt[i] = IDLE_HIGH;
                    cntNxt[i]   = CNT_ZERO;
                    outNxt[i]   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or
                posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            outq <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE_HIGH;
                cnt[i]   <= CNT_ZERO;
            end
        end else begin
            outq <= outNxt;
            for (int i = 0; i < 2; i++) begin
                state[i] <= stateNxt[i];
                cnt[i]   <= cntNxt[i];
            end
        end
    end

    assign SC_BUTTONCONDITIONER_clear_OutLow = outq[0];
    assign SC_BUTTONCONDITIONER_load_OutLow  = outq[1];

endmodule
